// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-master SRAM port arbiter.
package sram_arb_pkg;

   localparam int unsigned MEMORY_DATA_WIDTH = 8;
   localparam int unsigned MEMORY_ADDR_WIDTH = 9;

   // Master indices; their order is also the fixed priority order (LD > SPI > CPU)
   localparam int unsigned MST_LD  = 0;
   localparam int unsigned MST_SPI = 1;
   localparam int unsigned MST_CPU = 2;
   localparam int unsigned NUM_MST = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_LD  = 2'd1,
      OWN_SPI = 2'd2,
      OWN_CPU = 2'd3
   } arb_state_e;

   // Winner among the candidate requesters; prefer_cpu breaks a SPI/CPU tie
   function automatic arb_state_e arb_pick(input logic [NUM_MST-1:0] cand,
                                           input logic prefer_cpu);
      arb_state_e st;
      st = IDLE;
      if (cand[MST_LD])                         st = OWN_LD;
      else if (cand[MST_SPI] && cand[MST_CPU])  st = prefer_cpu ? OWN_CPU : OWN_SPI;
      else if (cand[MST_SPI])                   st = OWN_SPI;
      else if (cand[MST_CPU])                   st = OWN_CPU;
      return st;
   endfunction

endpackage

// File: rtl/arb_burst_timer.sv
// Burst-length timer: counts owned cycles while another master waits and
// flags when the owner has used up its burst allowance (MAX_BURST = 0: never).
module arb_burst_timer #(
   parameter int unsigned MAX_BURST       = 16,
   parameter int unsigned BURST_CNT_WIDTH = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic active_i,
   input  logic others_wait_i,
   input  logic owner_change_i,
   output logic expire_c_o
);

   localparam logic                       LIMIT_EN = (MAX_BURST != 0);
   localparam logic [BURST_CNT_WIDTH-1:0] LAST_CNT = BURST_CNT_WIDTH'(MAX_BURST - 1);

   logic [BURST_CNT_WIDTH-1:0] burst_cnt_q;
   logic [BURST_CNT_WIDTH-1:0] burst_cnt_d;

   // Count only while contended and the owner is unchanged; otherwise restart
   always_comb begin
      burst_cnt_d = '0;
      if (active_i && others_wait_i && !owner_change_i) begin
         burst_cnt_d = burst_cnt_q + BURST_CNT_WIDTH'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) burst_cnt_q <= '0;
      else       burst_cnt_q <= burst_cnt_d;
   end

   assign expire_c_o = LIMIT_EN && active_i && others_wait_i && (burst_cnt_q == LAST_CNT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Registered request/grant arbiter for the shared single-port SRAM (LD, SPI, CPU).
// Define SRAM_ARB_RR_EN to round-robin SPI/CPU ties; otherwise SPI beats CPU.
module sram_port_arbiter #(
   parameter int unsigned MEMORY_DATA_WIDTH = sram_arb_pkg::MEMORY_DATA_WIDTH,
   parameter int unsigned MEMORY_ADDR_WIDTH = sram_arb_pkg::MEMORY_ADDR_WIDTH,
   parameter int unsigned MAX_BURST         = 16,
   parameter int unsigned BURST_CNT_WIDTH   = 5
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         ld_req,
   input  logic                         cpu_req,
   input  logic                         spi_req,
   input  logic                         ld_en,
   input  logic                         cpu_en,
   input  logic                         spi_en,
   input  logic                         ld_we,
   input  logic                         cpu_we,
   input  logic                         spi_we,
   input  logic [MEMORY_ADDR_WIDTH-1:0] ld_addr,
   input  logic [MEMORY_ADDR_WIDTH-1:0] cpu_addr,
   input  logic [MEMORY_ADDR_WIDTH-1:0] spi_addr,
   input  logic [MEMORY_DATA_WIDTH-1:0] ld_din,
   input  logic [MEMORY_DATA_WIDTH-1:0] cpu_din,
   input  logic [MEMORY_DATA_WIDTH-1:0] spi_din,
   output logic                         ld_gnt,
   output logic                         cpu_gnt,
   output logic                         spi_gnt,
   output logic                         ld_qvld,
   output logic                         cpu_qvld,
   output logic                         spi_qvld,
   output logic [MEMORY_DATA_WIDTH-1:0] rdata,
   output logic                         CEN_after_mux,
   output logic                         WEN_after_mux,
   output logic [MEMORY_ADDR_WIDTH-1:0] A_after_mux,
   output logic [MEMORY_DATA_WIDTH-1:0] D_after_mux,
   input  logic [MEMORY_DATA_WIDTH-1:0] Q_from_SRAM
);

   import sram_arb_pkg::*;

   arb_state_e         state_q, state_d;
   logic [NUM_MST-1:0] gnt_q, gnt_d;
   logic [NUM_MST-1:0] qvld_q, qvld_d;
   logic [NUM_MST-1:0] req_v;
   logic               prefer_cpu;
   logic               burst_active;
   logic               others_wait;
   logic               owner_change;
   logic               expire;

   // Request vector indexed by master
   always_comb begin
      req_v          = '0;
      req_v[MST_LD]  = ld_req;
      req_v[MST_SPI] = spi_req;
      req_v[MST_CPU] = cpu_req;
   end

   // Contention seen by the current SPI/CPU owner (LD bursts are never limited)
   always_comb begin
      others_wait  = 1'b0;
      burst_active = 1'b0;
      case (state_q)
         OWN_SPI: begin burst_active = 1'b1; others_wait = ld_req | cpu_req; end
         OWN_CPU: begin burst_active = 1'b1; others_wait = ld_req | spi_req; end
         default: ;
      endcase
   end

   // Next owner: release or burst expiry hands over to the best remaining requester
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = arb_pick(req_v, prefer_cpu);
         OWN_LD:  if (!ld_req) state_d = arb_pick(req_v & 3'b110, prefer_cpu);
         OWN_SPI: if (!spi_req || expire) state_d = arb_pick(req_v & 3'b101, prefer_cpu);
         OWN_CPU: if (!cpu_req || expire) state_d = arb_pick(req_v & 3'b011, prefer_cpu);
         default: state_d = IDLE;
      endcase
   end

   assign owner_change = (state_d != state_q);

   arb_burst_timer #(
      .MAX_BURST       (MAX_BURST),
      .BURST_CNT_WIDTH (BURST_CNT_WIDTH)
   ) u_burst_timer (
      .clk_i          (CLK),
      .rst_i          (RST),
      .active_i       (burst_active),
      .others_wait_i  (others_wait),
      .owner_change_i (owner_change),
      .expire_c_o     (expire)
   );

`ifdef SRAM_ARB_RR_EN
   logic rr_q, rr_d;

   // Whoever just lost a SPI/CPU handover is preferred on the next tie
   always_comb begin
      rr_d = rr_q;
      if (owner_change) begin
         if (state_d == OWN_SPI && cpu_req)      rr_d = 1'b1;
         else if (state_d == OWN_CPU && spi_req) rr_d = 1'b0;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge CLK) begin
      if (RST) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end

   assign prefer_cpu = rr_q;
`else
   assign prefer_cpu = 1'b0;
`endif

   // Grant follows the next state; read-valid follows a granted read by one cycle
   always_comb begin
      gnt_d          = '0;
      gnt_d[MST_LD]  = (state_d == OWN_LD);
      gnt_d[MST_SPI] = (state_d == OWN_SPI);
      gnt_d[MST_CPU] = (state_d == OWN_CPU);
      qvld_d          = '0;
      qvld_d[MST_LD]  = gnt_q[MST_LD]  & ld_en  & ~ld_we;
      qvld_d[MST_SPI] = gnt_q[MST_SPI] & spi_en & ~spi_we;
      qvld_d[MST_CPU] = gnt_q[MST_CPU] & cpu_en & ~cpu_we;
   end

   // State, grant and read-valid registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         qvld_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         qvld_q  <= qvld_d;
      end
   end

   // SRAM pin mux from the owner only; nothing is issued while in reset
   always_comb begin
      CEN_after_mux = 1'b1;
      WEN_after_mux = 1'b1;
      A_after_mux   = '0;
      D_after_mux   = '0;
      if (!RST) begin
         case (state_q)
            OWN_LD: if (ld_en) begin
               CEN_after_mux = 1'b0; WEN_after_mux = ~ld_we;
               A_after_mux   = ld_addr; D_after_mux = ld_din;
            end
            OWN_SPI: if (spi_en) begin
               CEN_after_mux = 1'b0; WEN_after_mux = ~spi_we;
               A_after_mux   = spi_addr; D_after_mux = spi_din;
            end
            OWN_CPU: if (cpu_en) begin
               CEN_after_mux = 1'b0; WEN_after_mux = ~cpu_we;
               A_after_mux   = cpu_addr; D_after_mux = cpu_din;
            end
            default: ;
         endcase
      end
   end

   assign ld_gnt   = gnt_q[MST_LD];
   assign spi_gnt  = gnt_q[MST_SPI];
   assign cpu_gnt  = gnt_q[MST_CPU];
   assign ld_qvld  = qvld_q[MST_LD];
   assign spi_qvld = qvld_q[MST_SPI];
   assign cpu_qvld = qvld_q[MST_CPU];
   assign rdata    = Q_from_SRAM;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter (MAX_BURST = 4); follows SRAM_ARB_RR_EN.
module tb_sram_port_arbiter;

   localparam int MAXB = 4;
`ifdef SRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // master index: 0 = LD, 1 = SPI, 2 = CPU
   logic       clk = 1'b0;
   logic       rst;
   logic       req [3];
   logic       en  [3];
   logic       we  [3];
   logic [8:0] addr[3];
   logic [7:0] din [3];
   logic [7:0] q;

   logic       ld_gnt, spi_gnt, cpu_gnt, ld_qvld, spi_qvld, cpu_qvld;
   logic [7:0] rdata;
   logic       cen, wen;
   logic [8:0] a;
   logic [7:0] d;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int       m_owner = -1;
   int       m_cnt   = 0;
   bit       m_pref_cpu = 1'b0;
   bit [2:0] m_qv = '0;

   always #5 clk = ~clk;

   sram_port_arbiter #(
      .MEMORY_DATA_WIDTH (8),
      .MEMORY_ADDR_WIDTH (9),
      .MAX_BURST         (MAXB),
      .BURST_CNT_WIDTH   (3)
   ) dut (
      .CLK (clk), .RST (rst),
      .ld_req (req[0]), .cpu_req (req[2]), .spi_req (req[1]),
      .ld_en  (en[0]),  .cpu_en  (en[2]),  .spi_en  (en[1]),
      .ld_we  (we[0]),  .cpu_we  (we[2]),  .spi_we  (we[1]),
      .ld_addr (addr[0]), .cpu_addr (addr[2]), .spi_addr (addr[1]),
      .ld_din  (din[0]),  .cpu_din  (din[2]),  .spi_din  (din[1]),
      .ld_gnt (ld_gnt), .cpu_gnt (cpu_gnt), .spi_gnt (spi_gnt),
      .ld_qvld (ld_qvld), .cpu_qvld (cpu_qvld), .spi_qvld (spi_qvld),
      .rdata (rdata),
      .CEN_after_mux (cen), .WEN_after_mux (wen),
      .A_after_mux (a), .D_after_mux (d),
      .Q_from_SRAM (q)
   );

   // Behavioural model: owner keeps the bus until it lets go or uses MAXB contended cycles
   task automatic model_update();
      bit others, limit, spi_ok, cpu_ok;
      int nxt;
      if (rst) begin
         m_owner = -1; m_cnt = 0; m_pref_cpu = 1'b0; m_qv = '0;
         return;
      end
      for (int i = 0; i < 3; i++) m_qv[i] = (m_owner == i) && en[i] && !we[i];
      others = 1'b0;
      for (int i = 0; i < 3; i++) if (i != m_owner && req[i]) others = 1'b1;
      limit = (m_owner >= 1) && others && (m_cnt == MAXB - 1);
      nxt = m_owner;
      if (m_owner < 0 || !req[m_owner] || limit) begin
         nxt = -1;
         spi_ok = req[1] && (m_owner != 1);
         cpu_ok = req[2] && (m_owner != 2);
         if (req[0] && m_owner != 0)  nxt = 0;
         else if (spi_ok && cpu_ok)   nxt = (RR && m_pref_cpu) ? 2 : 1;
         else if (spi_ok)             nxt = 1;
         else if (cpu_ok)             nxt = 2;
      end
      if (RR && nxt != m_owner) begin
         if (nxt == 1 && req[2]) m_pref_cpu = 1'b1;
         if (nxt == 2 && req[1]) m_pref_cpu = 1'b0;
      end
      m_cnt   = (nxt == m_owner && m_owner >= 1 && others) ? m_cnt + 1 : 0;
      m_owner = nxt;
   endtask

   function automatic logic [2:0] exp_gnt();
      logic [2:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic logic [18:0] exp_pins();
      if (!rst && m_owner >= 0 && en[m_owner])
         return {1'b0, ~we[m_owner], addr[m_owner], din[m_owner]};
      return {1'b1, 1'b1, 9'd0, 8'd0};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; en[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; din[i] = '0;
      end
   endtask

   task automatic test_reset();
      idle_inputs(); q = 8'h00; rst = 1'b1;
      tick(); tick();
      @(negedge clk);
      n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", {cpu_gnt, spi_gnt, ld_gnt}); end
      n_tests++; if ({cpu_qvld, spi_qvld, ld_qvld} !== 3'b000) begin n_fail++; $display("FAIL reset_qvld: got %b want 000", {cpu_qvld, spi_qvld, ld_qvld}); end
      n_tests++; if ({cen, wen, a, d} !== 19'h60000) begin n_fail++; $display("FAIL reset_pins: got %h want 60000", {cen, wen, a, d}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_midburst();
      idle_inputs(); req[1] = 1'b1; en[1] = 1'b1; we[1] = 1'b0; addr[1] = 9'h055;
      tick();
      @(negedge clk);
      n_tests++; if ({spi_gnt, cen, a} !== {1'b1, 1'b0, 9'h055}) begin n_fail++; $display("FAIL midburst_own: got gnt=%b cen=%b a=%h want 1 0 055", spi_gnt, cen, a); end
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if (cen !== 1'b1) begin n_fail++; $display("FAIL reset_cycle_cen: got %b want 1", cen); end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== 3'b000) begin n_fail++; $display("FAIL midburst_gnt: got %b want 000", {cpu_gnt, spi_gnt, ld_gnt}); end
      n_tests++; if ({cen, a, spi_qvld} !== {1'b1, 9'h000, 1'b0}) begin n_fail++; $display("FAIL midburst_pins: got cen=%b a=%h qvld=%b want 1 000 0", cen, a, spi_qvld); end
      idle_inputs();
      tick();
   endtask

   task automatic test_cpu_read();
      idle_inputs(); req[2] = 1'b1; en[2] = 1'b1; we[2] = 1'b0; addr[2] = 9'h012; q = 8'hA5;
      @(negedge clk);
      n_tests++; if (cen !== 1'b1) begin n_fail++; $display("FAIL nonowner_en: got cen=%b want 1", cen); end
      tick();
      @(negedge clk);
      n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== 3'b100) begin n_fail++; $display("FAIL cpu_gnt: got %b want 100", {cpu_gnt, spi_gnt, ld_gnt}); end
      n_tests++; if ({cen, wen, a} !== {1'b0, 1'b1, 9'h012}) begin n_fail++; $display("FAIL cpu_pins: got %b %b %h want 0 1 012", cen, wen, a); end
      tick();
      @(negedge clk);
      n_tests++; if ({cpu_qvld, spi_qvld, ld_qvld} !== 3'b100) begin n_fail++; $display("FAIL cpu_qvld: got %b want 100", {cpu_qvld, spi_qvld, ld_qvld}); end
      n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL cpu_rdata: got %h want a5", rdata); end
      idle_inputs();
      tick();
   endtask

   task automatic test_priority();
      idle_inputs(); rst = 1'b1; tick(); rst = 1'b0;
      req[0] = 1'b1; req[1] = 1'b1; req[2] = 1'b1;
      tick(); @(negedge clk);
      n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== 3'b001) begin n_fail++; $display("FAIL prio_ld: got %b want 001", {cpu_gnt, spi_gnt, ld_gnt}); end
      req[0] = 1'b0;
      tick(); @(negedge clk);
      n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== 3'b010) begin n_fail++; $display("FAIL prio_spi: got %b want 010", {cpu_gnt, spi_gnt, ld_gnt}); end
      req[1] = 1'b0;
      tick(); @(negedge clk);
      n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== 3'b100) begin n_fail++; $display("FAIL prio_cpu: got %b want 100", {cpu_gnt, spi_gnt, ld_gnt}); end
      idle_inputs();
      tick();
   endtask

   task automatic test_burst_limit();
      int  spi_cycles;
      bit  seen_cpu;
      idle_inputs(); req[1] = 1'b1;
      tick();
      req[2] = 1'b1;
      spi_cycles = 0; seen_cpu = 1'b0;
      for (int i = 0; i < 12 && !seen_cpu; i++) begin
         @(negedge clk);
         n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== exp_gnt()) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b want %b", i, {cpu_gnt, spi_gnt, ld_gnt}, exp_gnt()); end
         if (cpu_gnt) seen_cpu = 1'b1;
         else if (spi_gnt) spi_cycles++;
         tick();
      end
      n_tests++; if (!seen_cpu || spi_cycles != MAXB) begin n_fail++; $display("FAIL burst_len: got cpu=%0d spi_cycles=%0d want 1 %0d", seen_cpu, spi_cycles, MAXB); end
      req[2] = 1'b0;
      tick(); @(negedge clk);
      n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== 3'b010) begin n_fail++; $display("FAIL burst_regain: got %b want 010", {cpu_gnt, spi_gnt, ld_gnt}); end
      idle_inputs();
      tick();
   endtask

   task automatic test_ld_no_preempt();
      idle_inputs(); req[0] = 1'b1;
      tick();
      req[1] = 1'b1; req[2] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== 3'b001) begin n_fail++; $display("FAIL ld_hold[%0d]: got %b want 001", i, {cpu_gnt, spi_gnt, ld_gnt}); end
         tick();
      end
      req[0] = 1'b0;
      tick(); @(negedge clk);
      n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== exp_gnt() || ld_gnt !== 1'b0) begin n_fail++; $display("FAIL ld_release: got %b want %b", {cpu_gnt, spi_gnt, ld_gnt}, exp_gnt()); end
      idle_inputs();
      tick();
   endtask

   task automatic test_alternate();
      int changes;
      logic [2:0] prev;
      idle_inputs(); req[1] = 1'b1; req[2] = 1'b1;
      tick();
      changes = 0; prev = 3'b000;
      for (int i = 0; i < 4 * MAXB + 2; i++) begin
         @(negedge clk);
         n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== exp_gnt()) begin n_fail++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, {cpu_gnt, spi_gnt, ld_gnt}, exp_gnt()); end
         if (i > 0 && {cpu_gnt, spi_gnt, ld_gnt} != prev) changes++;
         prev = {cpu_gnt, spi_gnt, ld_gnt};
         tick();
      end
      n_tests++; if (changes != 4) begin n_fail++; $display("FAIL alt_handovers: got %0d want 4", changes); end
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      idle_inputs();
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(7) == 0) req[k] = ~req[k];
            en[k]   = 1'($urandom_range(1));
            we[k]   = 1'($urandom_range(1));
            addr[k] = 9'($urandom);
            din[k]  = 8'($urandom);
         end
         q   = 8'($urandom);
         rst = ($urandom_range(63) == 0);
         @(negedge clk);
         n_tests++; if ({cpu_gnt, spi_gnt, ld_gnt} !== exp_gnt()) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", i, {cpu_gnt, spi_gnt, ld_gnt}, exp_gnt()); end
         n_tests++; if ({cpu_qvld, spi_qvld, ld_qvld} !== m_qv) begin n_fail++; $display("FAIL rnd_qvld[%0d]: got %b want %b", i, {cpu_qvld, spi_qvld, ld_qvld}, m_qv); end
         n_tests++; if ({cen, wen, a, d} !== exp_pins()) begin n_fail++; $display("FAIL rnd_pins[%0d]: got %h want %h", i, {cen, wen, a, d}, exp_pins()); end
         n_tests++; if (rdata !== q) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rdata, q); end
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      q   = 8'h00;
      test_reset();
      test_reset_midburst();
      test_cpu_read();
      test_priority();
      test_burst_limit();
      test_ld_no_preempt();
      test_alternate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Sequential arbiter for the single-port 512x8 SRAM shared by three masters: the serial loader (LD), the 8-bit serial CPU (CPU) and the pseudo-SPI streamer (SPI).
- Replaces the static combinational SRAM mux with registered request/grant handshakes.
- Enforces burst ownership and a bounded burst length.
- Returns tagged read-valid strobes that follow the SRAM's 1-cycle read latency.
- Sits between the three masters and the SRAM macro pins (CEN_after_mux, WEN_after_mux, A_after_mux, D_after_mux, Q_from_SRAM).

Parameters:
MEMORY_DATA_WIDTH, 8, SRAM word width.
MEMORY_ADDR_WIDTH, 9, SRAM address width.
MAX_BURST, 16, maximum consecutive granted cycles for CPU/SPI while another master waits; 0 = unlimited.
BURST_CNT_WIDTH, 5, width of the burst counter; must satisfy 2^BURST_CNT_WIDTH > MAX_BURST.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous reset, active-high.
ld_req / cpu_req / spi_req  in  1 each  bus request; held high for the whole burst.
ld_en / cpu_en / spi_en  in  1 each  access this cycle (active-high).
ld_we / cpu_we / spi_we  in  1 each  1 = write, 0 = read.
ld_addr / cpu_addr / spi_addr  in  MEMORY_ADDR_WIDTH each  access address.
ld_din / cpu_din / spi_din  in  MEMORY_DATA_WIDTH each  write data.
ld_gnt / cpu_gnt / spi_gnt  out  1 each  registered grant; one-hot or all zero.
ld_qvld / cpu_qvld / spi_qvld  out  1 each  read data valid on rdata.
rdata  out  MEMORY_DATA_WIDTH  Q_from_SRAM passed through to all masters.
CEN_after_mux  out  1  SRAM chip enable, active-low.
WEN_after_mux  out  1  SRAM write enable, active-low.
A_after_mux  out  MEMORY_ADDR_WIDTH  SRAM address.
D_after_mux  out  MEMORY_DATA_WIDTH  SRAM write data.
Q_from_SRAM  in  MEMORY_DATA_WIDTH  SRAM read data.

Behaviour:
- **Reset (RST=1 at an edge, including mid-burst):**
  - state=IDLE; all gnt=0; all qvld=0; burst_cnt=0.
  - SRAM pins: CEN_after_mux=1, WEN_after_mux=1, A_after_mux=0, D_after_mux=0.
  - No access is issued in the reset cycle.
- **States:** IDLE, OWN_LD, OWN_SPI, OWN_CPU.
  - Each gnt output is registered and is 1 only in its own state.
- **Arbitration** is evaluated at each edge from the sampled req lines:
  - Fixed priority LD > SPI > CPU.
  - IDLE -> OWN_x for the highest-priority requester, so grant latency is 1 cycle.
  - OWN_x -> next winner or IDLE when req_x drops.
  - The owner changes directly without an idle cycle.
- **Preemption and burst limit:**
  - LD is never preempted and may preempt nobody; it waits for the current owner to release or hit its limit.
  - burst_cnt increments each cycle in OWN_SPI/OWN_CPU while any other req is high; it clears on an owner change or when no other master waits.
  - If burst_cnt == MAX_BURST-1 and another master waits, the grant moves to the highest-priority waiting master at the next edge.
  - A preempted master keeps req high and is re-arbitrated normally.
- **SRAM pins** are combinational from the owner's inputs when the owner's en=1:
  - CEN_after_mux = 0.
  - WEN_after_mux = ~we.
  - A_after_mux / D_after_mux = owner's addr / din.
  - Otherwise CEN_after_mux=1, WEN_after_mux=1, and addr/data hold 0.
  - Non-owner en is ignored.
- **Read valid:** x_qvld is registered and asserted the cycle after (gnt_x & en_x & ~we_x).
  - It is still delivered if the grant changes on that same edge.
- **Same-edge events:** req dropping while the counter expires resolves as a plain release.
  - All three reqs rising together from IDLE resolves to LD.

Optional Feature:
SRAM_ARB_RR_EN
- Defined: CPU and SPI share a round-robin pointer. The one that last lost a CPU-vs-SPI decision wins the next tie. LD keeps absolute priority.
- Undefined: fixed SPI > CPU, as above.

Decomposition:
- Shared package sram_arb_pkg:
  - State encoding: IDLE=2'd0, OWN_LD=2'd1, OWN_SPI=2'd2, OWN_CPU=2'd3.
  - Master index constants.
  - MEMORY_DATA_WIDTH / MEMORY_ADDR_WIDTH defaults.
- One natural sub-module, arb_burst_timer:
  - Contents: burst_cnt, clear/increment logic and the expire flag.
  - Parameterised by MAX_BURST and BURST_CNT_WIDTH.

Test Plan:
1. Reset mid-burst: SPI owning with spi_en=1; assert RST one cycle -> next edge all gnt=0, CEN_after_mux=1, A_after_mux=0, spi_qvld=0.
2. CPU read alone: cpu_req=1 at edge t -> cpu_gnt=1 at t+1. With cpu_en=1, cpu_we=0, cpu_addr=9'h012, the pins show CEN_after_mux=0, WEN_after_mux=1, A_after_mux=9'h012. At t+2, cpu_qvld=1 and rdata=Q_from_SRAM (8'hA5).
3. Simultaneous ld/spi/cpu req from IDLE -> ld_gnt only. Drop ld_req -> spi_gnt next edge. Drop spi_req -> cpu_gnt next edge.
4. MAX_BURST=4: SPI owns, cpu_req held high -> spi_gnt high exactly 4 cycles, then cpu_gnt. SPI keeps req and regains the grant after cpu_req drops.
5. LD owns for 20 cycles with cpu_req and spi_req high -> no preemption. On LD release, spi_gnt (RR off) or the RR winner (SRAM_ARB_RR_EN).
6. SRAM_ARB_RR_EN with cpu_req and spi_req held high, MAX_BURST=4 -> owner alternates SPI, CPU, SPI, CPU in 4-cycle bursts.
